// File: rtl/foodfight_rom_busctl.sv
// rtl/foodfight_rom_busctl.sv - 68000 bus controller for the Food Fight program ROMs
//
// Decodes CPU cycles that fall in the 64 KB program-ROM window, presents a
// registered word address and one-hot chip enable to four synchronous
// 8K x 16 ROMs, waits out their read latency, captures the selected word
// onto cpu_d and acknowledges with cpu_dtack_n. Writes into the window are
// acknowledged without touching the ROMs and flagged on rom_wr_err.
//
// Parameters:
//   ROM_LAT   clock edges from a registered ROM address to valid ROM data (1..7)
//   BASE      value cpu_a[23:16] must carry for the ROM window
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   cpu_a        CPU word address A[23:1] (bit k of the vector is address line Ak)
//   cpu_as_n     address strobe, active low
//   cpu_rw       1 = read, 0 = write
//   cpu_uds_n    upper data strobe, active low
//   cpu_lds_n    lower data strobe, active low
//   cpu_d        read data to the CPU, holds the last captured word
//   cpu_dtack_n  data acknowledge, active low
//   rom_a        registered ROM word address
//   rom_ce       one-hot ROM chip enables
//   rom_oe       ROM output enable
//   rom_d        ROM data, ROM i on rom_d[16i+15:16i]
//   rom_wr_err   one-cycle pulse on a write into the ROM window

module foodfight_rom_busctl #(
    parameter int         ROM_LAT = 1,
    parameter logic [7:0] BASE    = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:1] cpu_a,
    input  logic        cpu_as_n,
    input  logic        cpu_rw,
    input  logic        cpu_uds_n,
    input  logic        cpu_lds_n,
    output logic [15:0] cpu_d,
    output logic        cpu_dtack_n,
    output logic [12:0] rom_a,
    output logic [3:0]  rom_ce,
    output logic        rom_oe,
    input  logic [63:0] rom_d,
    output logic        rom_wr_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2,
        ACK  = 2'd3
    } state_t;

    // The WAIT state consumes ROM_LAT edges before CAPT samples rom_d.
    localparam logic [2:0] CNT_LOAD = 3'(ROM_LAT - 1);

    state_t      state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic [1:0]  sel, sel_n;      // ROM chosen for the access in flight
    logic        wr, wr_n;        // access in flight is a rejected write
    logic [15:0] cpu_d_n;
    logic        cpu_dtack_n_n;
    logic [12:0] rom_a_n;
    logic [3:0]  rom_ce_n;
    logic        rom_oe_n;
    logic        rom_wr_err_n;
    logic        hit;

    assign hit = !cpu_as_n && (cpu_a[23:16] == BASE) && (!cpu_uds_n || !cpu_lds_n);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            sel         <= 2'd0;
            wr          <= 1'b0;
            cpu_d       <= 16'h0000;
            cpu_dtack_n <= 1'b1;
            rom_a       <= 13'd0;
            rom_ce      <= 4'b0000;
            rom_oe      <= 1'b0;
            rom_wr_err  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sel         <= sel_n;
            wr          <= wr_n;
            cpu_d       <= cpu_d_n;
            cpu_dtack_n <= cpu_dtack_n_n;
            rom_a       <= rom_a_n;
            rom_ce      <= rom_ce_n;
            rom_oe      <= rom_oe_n;
            rom_wr_err  <= rom_wr_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        sel_n         = sel;
        wr_n          = wr;
        cpu_d_n       = cpu_d;
        cpu_dtack_n_n = cpu_dtack_n;
        rom_a_n       = rom_a;
        rom_ce_n      = rom_ce;
        rom_oe_n      = rom_oe;
        rom_wr_err_n  = 1'b0;

        case (state)
            IDLE: begin
                if (hit) begin
                    sel_n = cpu_a[15:14];
                    if (cpu_rw) begin
                        wr_n     = 1'b0;
                        rom_a_n  = cpu_a[13:1];
                        rom_ce_n = 4'b0001 << cpu_a[15:14];
                        rom_oe_n = 1'b1;
                        cnt_n    = CNT_LOAD;
                        state_n  = WAIT;
                    end else begin
                        // Writes borrow CAPT as their one-cycle delay so the
                        // acknowledge lands one edge after the hit, with the
                        // ROMs never enabled.
                        wr_n    = 1'b1;
                        state_n = CAPT;
                    end
                end
            end

            WAIT: begin
                if (cpu_as_n) begin
                    rom_ce_n = 4'b0000;
                    rom_oe_n = 1'b0;
                    state_n  = IDLE;
                end else if (cnt == 3'd0) begin
                    state_n = CAPT;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end

            CAPT: begin
                rom_ce_n = 4'b0000;
                rom_oe_n = 1'b0;
                if (cpu_as_n) begin
                    state_n = IDLE;
                end else begin
                    if (wr) begin
                        rom_wr_err_n = 1'b1;
                    end else begin
                        cpu_d_n = rom_d[{sel, 4'b0000} +: 16];
                    end
                    cpu_dtack_n_n = 1'b0;
                    state_n       = ACK;
                end
            end

            ACK: begin
                if (cpu_as_n) begin
                    cpu_dtack_n_n = 1'b1;
                    state_n       = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_foodfight_rom_busctl.sv
// tb/tb_foodfight_rom_busctl.sv - scoreboard bench for foodfight_rom_busctl

module tb_foodfight_rom_busctl;

    localparam int         LAT  = 3;
    localparam logic [7:0] BASE = 8'h00;

    logic        clk;
    logic        reset_n;
    logic [23:1] cpu_a;
    logic        cpu_as_n;
    logic        cpu_rw;
    logic        cpu_uds_n;
    logic        cpu_lds_n;
    logic [15:0] cpu_d;
    logic        cpu_dtack_n;
    logic [12:0] rom_a;
    logic [3:0]  rom_ce;
    logic        rom_oe;
    logic [63:0] rom_d;
    logic        rom_wr_err;

    foodfight_rom_busctl #(.ROM_LAT(LAT), .BASE(BASE)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_a       (cpu_a),
        .cpu_as_n    (cpu_as_n),
        .cpu_rw      (cpu_rw),
        .cpu_uds_n   (cpu_uds_n),
        .cpu_lds_n   (cpu_lds_n),
        .cpu_d       (cpu_d),
        .cpu_dtack_n (cpu_dtack_n),
        .rom_a       (rom_a),
        .rom_ce      (rom_ce),
        .rom_oe      (rom_oe),
        .rom_d       (rom_d),
        .rom_wr_err  (rom_wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Four synchronous ROMs: address registered on the edge after rom_a
    // changes, data emerges LAT edges after rom_a became valid.
    logic [15:0] mem [4][8192];
    logic [63:0] pipe [LAT];

    always @(posedge clk) begin
        pipe[0] <= {mem[3][rom_a], mem[2][rom_a], mem[1][rom_a], mem[0][rom_a]};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rom_d = pipe[LAT-1];

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] d;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] last_d = 16'h0000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every acknowledge must match the oldest expectation; between
    // acknowledges cpu_d must hold and rom_wr_err must stay low.
    logic        prev_dtack = 1'b1;
    logic [15:0] prev_d     = 16'h0000;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_dtack && !cpu_dtack_n) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_dtack: got dtack with no access pending at %0t", $time);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("ack_data", cpu_d, mon_e.d);
                    chk("ack_wr_err", rom_wr_err, mon_e.err);
                end
            end else begin
                chk("d_stable", cpu_d, prev_d);
                chk("wr_err_quiet", rom_wr_err, 0);
            end
        end
        prev_dtack = cpu_dtack_n;
        prev_d     = cpu_d;
    end

    // One CPU cycle into the window. abort_j > 0 raises AS so that it is
    // sampled high j edges after the hit; hold adds cycles with DTACK low.
    task automatic access(input logic [23:1] a, input logic rw, input logic uds,
                          input logic lds, input int abort_j, input int hold);
        exp_t       e;
        int         k;
        logic [1:0] s;
        s = a[15:14];
        if (abort_j == 0) begin
            if (rw) begin
                e.d    = mem[s][a[13:1]];
                e.err  = 1'b0;
                last_d = e.d;
            end else begin
                e.d   = last_d;
                e.err = 1'b1;
            end
            sbq.push_back(e);
        end
        cpu_a = a; cpu_rw = rw; cpu_uds_n = uds; cpu_lds_n = lds; cpu_as_n = 1'b0;
        @(negedge clk);
        if (rw) begin
            chk("rom_a", rom_a, a[13:1]);
            chk("rom_ce", rom_ce, 4'b0001 << s);
            chk("rom_oe", rom_oe, 1);
        end else begin
            chk("wr_rom_ce", rom_ce, 0);
        end
        if (abort_j > 0) begin
            for (int j = 1; j < abort_j; j++) @(negedge clk);
            cpu_as_n = 1'b1;
            for (int j = 0; j < LAT + 3; j++) begin
                @(negedge clk);
                chk("abort_dtack", cpu_dtack_n, 1);
            end
            chk("abort_ce", rom_ce, 0);
            chk("abort_oe", rom_oe, 0);
            return;
        end
        k = 1;
        while (cpu_dtack_n !== 1'b0 && k < 30) begin
            @(negedge clk);
            k++;
            if (!rw) chk("wr_rom_ce", rom_ce, 0);
        end
        chk("ack_latency", k, rw ? LAT + 2 : 2);
        for (int j = 0; j < hold; j++) begin
            @(negedge clk);
            chk("dtack_hold", cpu_dtack_n, 0);
        end
        cpu_as_n = 1'b1;
        @(negedge clk);
        chk("dtack_release", cpu_dtack_n, 1);
    endtask

    task automatic miss(input logic [23:1] a, input logic uds, input logic lds, input int cycles);
        cpu_a = a; cpu_rw = 1'b1; cpu_uds_n = uds; cpu_lds_n = lds; cpu_as_n = 1'b0;
        for (int j = 0; j < cycles; j++) begin
            @(negedge clk);
            chk("miss_dtack", cpu_dtack_n, 1);
            chk("miss_ce", rom_ce, 0);
        end
        cpu_as_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int          r;
        int          u;
        logic [23:1] a;
        logic        uds;
        logic        lds;

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 8192; j++) mem[i][j] = 16'($urandom);
        mem[2][13'h0123] = 16'hBEEF;

        reset_n = 1'b0; cpu_as_n = 1'b1; cpu_rw = 1'b1;
        cpu_uds_n = 1'b1; cpu_lds_n = 1'b1; cpu_a = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cpu_d", cpu_d, 16'h0000);
        chk("rst_dtack", cpu_dtack_n, 1);
        chk("rst_rom_a", rom_a, 0);
        chk("rst_rom_ce", rom_ce, 0);
        chk("rst_rom_oe", rom_oe, 0);
        chk("rst_wr_err", rom_wr_err, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // ROM2, word 0x0123: A15:A14 = 2, A13:A1 = 0x0123
        access(23'h004123, 1'b1, 1'b0, 1'b0, 0, 1);
        chk("beef_read", cpu_d, 16'hBEEF);
        access(23'h000010, 1'b0, 1'b0, 1'b1, 0, 0);
        chk("wr_keeps_d", cpu_d, 16'hBEEF);
        miss({8'h80, 15'h4123}, 1'b0, 1'b0, 10);
        miss({BASE, 15'h4123}, 1'b1, 1'b1, 3);
        access(23'h004123, 1'b1, 1'b0, 1'b0, 1, 0);
        chk("abort_keeps_d", cpu_d, 16'hBEEF);
        for (int s = 0; s < 4; s++) begin
            a = {BASE, 2'(s), 13'(s * 1031 + 7)};
            mem[s][13'(s * 1031 + 7)] = 16'h1111 * 16'(s + 1) ^ 16'hA5C3;
            access(a, 1'b1, 1'(s & 1), 1'(~s & 1), 0, s % 3);
        end

        // Asynchronous reset in the middle of a WAIT
        cpu_a = 23'h004123; cpu_rw = 1'b1; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_as_n = 1'b0;
        @(negedge clk);
        chk("pre_rst_ce", rom_ce, 4'b0100);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_ce", rom_ce, 0);
        chk("async_rst_dtack", cpu_dtack_n, 1);
        chk("async_rst_d", cpu_d, 16'h0000);
        chk("async_rst_oe", rom_oe, 0);
        cpu_as_n = 1'b1;
        last_d = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 99);
            u = $urandom_range(0, 2);
            uds = (u == 2);
            lds = (u == 1);
            a = {BASE, 15'($urandom)};
            if (r < 55) begin
                access(a, 1'b1, uds, lds, 0, $urandom_range(0, 2));
            end else if (r < 70) begin
                access(a, 1'b0, uds, lds, 0, $urandom_range(0, 2));
            end else if (r < 85) begin
                access(a, 1'b1, uds, lds, $urandom_range(1, LAT + 1), 0);
            end else if (r < 93) begin
                miss({BASE ^ 8'($urandom_range(1, 255)), a[15:1]}, uds, lds, $urandom_range(1, 4));
            end else begin
                miss(a, 1'b1, 1'b1, $urandom_range(1, 4));
            end
        end

        @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
